// File: rtl/step_ctrl_pkg.sv
// Shared mode encoding for the debug step controller and the display path.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE = 2'b00,
    MODE_STEP = 2'b01,
    MODE_RUN  = 2'b10,
    MODE_HALT = 2'b11
  } mode_t;

  function automatic logic mode_is_halt(input mode_t m);
    return m == MODE_HALT;
  endfunction

endpackage

// File: rtl/step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, one-clk
// event on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_ev
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_ev;

  // The level must disagree with the accepted level for DEBOUNCE_CYCLES
  // consecutive samples before it is taken; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_ev    <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_ev   <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_ev    <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_ev = r_ev;

endmodule

// File: rtl/step_ctrl.sv
// Debug clock-enable sequencer: manual step, divided free-run, PC breakpoint
// halt, and a wrapping count of issued advance pulses.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int RUN_DIV         = 50000000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_step,
  input  logic             btn_run,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  output logic             cpu_en,
  output logic [1:0]       mode,
  output logic             halted,
  output logic [CNT_W-1:0] step_count
);

  localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(RUN_DIV - 1);

  logic w_step_ev;
  logic w_run_ev;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .clk   (clk),
    .reset (reset),
    .i_btn (btn_step),
    .o_ev  (w_step_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk   (clk),
    .reset (reset),
    .i_btn (btn_run),
    .o_ev  (w_run_ev)
  );

  mode_t            r_state;
  logic [DW-1:0]    r_div;
  logic             r_skip_bp;
  logic             r_cpu_en;
  logic [CNT_W-1:0] r_step_count;

  mode_t            w_state_next;
  logic [DW-1:0]    w_div_next;
  logic             w_skip_next;
  logic             w_cpu_en_next;
  logic [CNT_W-1:0] w_count_next;
  logic             w_tick;
  logic             w_bp_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= MODE_IDLE;
      r_div        <= '0;
      r_skip_bp    <= 1'b0;
      r_cpu_en     <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_div        <= w_div_next;
      r_skip_bp    <= w_skip_next;
      r_cpu_en     <= w_cpu_en_next;
      r_step_count <= w_count_next;
    end
  end

  assign w_tick   = (r_div == DIV_MAX);
  assign w_bp_hit = bp_en && (pc == bp_addr) && !r_skip_bp;

  // The divider is held at zero outside RUN, so every entry into RUN starts
  // a full period. cpu_en is registered alongside the transition into STEP.
  always_comb begin
    w_state_next  = r_state;
    w_div_next    = '0;
    w_skip_next   = r_skip_bp;
    w_cpu_en_next = 1'b0;
    case (r_state)
      MODE_IDLE: begin
        if (w_run_ev) begin
          w_state_next = MODE_RUN;
        end else if (w_step_ev) begin
          w_state_next  = MODE_STEP;
          w_cpu_en_next = 1'b1;
        end
      end
      MODE_STEP: begin
        w_state_next = MODE_IDLE;
      end
      MODE_RUN: begin
        if (w_run_ev) begin
          w_state_next = MODE_IDLE;
        end else if (w_tick) begin
          if (w_bp_hit) begin
            w_state_next = MODE_HALT;
          end else begin
            w_cpu_en_next = 1'b1;
            w_skip_next   = 1'b0;
          end
        end else begin
          w_div_next = r_div + DW'(1);
        end
      end
      MODE_HALT: begin
        if (w_run_ev) begin
          w_state_next = MODE_RUN;
          w_skip_next  = 1'b1;
        end else if (w_step_ev) begin
          w_state_next  = MODE_STEP;
          w_cpu_en_next = 1'b1;
        end
      end
      default: begin
        w_state_next = MODE_IDLE;
      end
    endcase
    w_count_next = w_cpu_en_next ? r_step_count + CNT_W'(1) : r_step_count;
  end

  always_comb begin
    mode       = r_state;
    halted     = mode_is_halt(r_state);
    cpu_en     = r_cpu_en;
    step_count = r_step_count;
  end

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with a short debounce and run divider; a small
// processor model advances pc by 4 on each cpu_en.
module tb_step_ctrl;

  localparam int DB = 4;
  localparam int RD = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_step;
  logic          btn_run;
  logic          bp_en;
  logic [31:0]   bp_addr;
  logic [31:0]   pc;
  logic          cpu_en;
  logic [1:0]    mode;
  logic          halted;
  logic [CW-1:0] step_count;

  logic pc_clr;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   consec = 0;
  int   t_last = 0;
  int   t_prev = 0;
  logic prev_en = 1'b0;

  always #5 clk = ~clk;

  step_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .RUN_DIV        (RD),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_step   (btn_step),
    .btn_run    (btn_run),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .cpu_en     (cpu_en),
    .mode       (mode),
    .halted     (halted),
    .step_count (step_count)
  );

  // Processor model: pc advances on the edge that ends a cpu_en cycle.
  always @(posedge clk) begin
    if (pc_clr) pc <= 32'd0;
    else if (cpu_en) pc <= pc + 32'd4;
  end

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc     <= cyc + 1;
    prev_en <= cpu_en;
    if (cpu_en === 1'b1) begin
      pulses <= pulses + 1;
      t_prev <= t_last;
      t_last <= cyc;
    end
    if (cpu_en === 1'b1 && prev_en === 1'b1) consec <= consec + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press(input logic s, input logic r, input int hold);
    btn_step = s;
    btn_run  = r;
    cycles(hold);
    btn_step = 1'b0;
    btn_run  = 1'b0;
    cycles(10);
  endtask

  task automatic wait_pulses(input string tag, input int target, input int budget);
    int k = 0;
    while (pulses < target && k < budget) begin
      cycles(1);
      k++;
    end
    chk(tag, 32'(pulses >= target), 32'd1);
  endtask

  task automatic do_reset(input int n);
    reset  = 1'b1;
    pc_clr = 1'b1;
    cycles(n);
    reset  = 1'b0;
    pc_clr = 1'b0;
  endtask

  initial begin
    int base;
    int mark;
    int k;
    logic [CW-1:0] cnt_mark;

    reset    = 1'b1;
    pc_clr   = 1'b1;
    btn_step = 1'b0;
    btn_run  = 1'b0;
    bp_en    = 1'b0;
    bp_addr  = 32'd0;

    // 1: reset state
    do_reset(3);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", 32'(step_count), 32'd0);
    base = pulses;

    // 2: a 3-cycle glitch is rejected, a long hold gives exactly one step
    btn_step = 1'b1;
    cycles(3);
    btn_step = 1'b0;
    cycles(12);
    chk("glitch_pulses", 32'(pulses - base), 32'd0);
    chk("glitch_mode", 32'(mode), 32'd0);
    press(1'b1, 1'b0, 12);
    chk("step_pulses", 32'(pulses - base), 32'd1);
    chk("step_count", 32'(step_count), 32'd1);
    chk("step_mode", 32'(mode), 32'd0);

    // 3: free run at RUN_DIV, then pause
    press(1'b0, 1'b1, 8);
    chk("run_mode", 32'(mode), 32'd2);
    mark = pulses;
    wait_pulses("run_pulses_seen", mark + 2, 30);
    chk("run_period", 32'(t_last - t_prev), 32'(RD));
    press(1'b0, 1'b1, 8);
    mark     = pulses;
    cnt_mark = step_count;
    cycles(20);
    chk("pause_mode", 32'(mode), 32'd0);
    chk("pause_pulses", 32'(pulses - mark), 32'd0);
    chk("pause_count", 32'(step_count), 32'(cnt_mark));
    chk("count_tracks_pulses", 32'(step_count), 32'((pulses - base) % 16));

    // 4: breakpoint at 0x10 halts after four pulses, resume skips it once
    do_reset(2);
    base    = pulses;
    bp_en   = 1'b1;
    bp_addr = 32'h10;
    btn_run = 1'b1;
    k = 0;
    while (mode !== 2'b11 && k < 80) begin
      cycles(1);
      k++;
      if (k == 8) btn_run = 1'b0;
    end
    chk("bp_mode", 32'(mode), 32'd3);
    chk("bp_halted", 32'(halted), 32'd1);
    chk("bp_pc", pc, 32'h10);
    chk("bp_count", 32'(step_count), 32'd4);
    chk("bp_pulses", 32'(pulses - base), 32'd4);
    cycles(12);
    chk("bp_stays_halted", 32'(mode), 32'd3);
    btn_run = 1'b1;
    wait_pulses("resume_pulse_seen", base + 5, 40);
    cycles(1);
    chk("resume_pc", pc, 32'h14);
    chk("resume_count", 32'(step_count), 32'd5);
    chk("resume_mode", 32'(mode), 32'd2);
    chk("resume_halted", 32'(halted), 32'd0);
    btn_run = 1'b0;
    bp_en   = 1'b0;

    // 5: sixteen manual steps wrap the count; simultaneous events favour run
    do_reset(2);
    base = pulses;
    for (int i = 0; i < 16; i++) begin
      press(1'b1, 1'b0, 6);
      if (i == 14) chk("count_15", 32'(step_count), 32'hF);
    end
    chk("wrap_count", 32'(step_count), 32'd0);
    chk("wrap_pulses", 32'(pulses - base), 32'd16);
    chk("wrap_mode", 32'(mode), 32'd0);
    mark     = pulses;
    btn_step = 1'b1;
    btn_run  = 1'b1;
    k = 0;
    while (mode === 2'b00 && k < 20) begin
      cycles(1);
      k++;
    end
    chk("both_mode", 32'(mode), 32'd2);
    chk("both_no_step", 32'(pulses - mark), 32'd0);
    cycles(1);
    chk("both_no_step_late", 32'(pulses - mark), 32'd0);
    btn_step = 1'b0;
    btn_run  = 1'b0;

    // 6: reset lands on the edge that would issue a run pulse
    mark = pulses;
    wait_pulses("pre_reset_pulse", mark + 1, 20);
    cycles(RD - 1);
    mark  = pulses;
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    chk("midrst_cpu_en", 32'(cpu_en), 32'd0);
    chk("midrst_mode", 32'(mode), 32'd0);
    chk("midrst_count", 32'(step_count), 32'd0);
    chk("midrst_pulses", 32'(pulses - mark), 32'd0);
    cycles(12);
    chk("post_rst_idle", 32'(pulses - mark), 32'd0);
    chk("no_back_to_back", 32'(consec), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
